// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry, parity and
// the command bytes the host sends to a keyboard.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    // data[7:0], parity, stop
    localparam int FRAME_BITS = 10;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Three-flop synchroniser for the PS/2 clock and data lines plus clock falling-edge
// detect; the same block serves the keyboard receive path.
module ps2_line_sync (
    input  logic clk,
    input  logic clrn,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    logic [2:0] clk_sr;
    logic [2:0] data_sr;

    // Idle PS/2 lines are high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sr  <= '1;
            data_sr <= '1;
        end else begin
            clk_sr  <= {clk_sr[1:0], ps2_clk_in};
            data_sr <= {data_sr[1:0], ps2_data_in};
        end
    end

    assign clk_sync  = clk_sr[2];
    assign data_sync = data_sr[2];
    assign clk_fall  = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, requests to send, shifts one
// command byte out on device clock falls and checks the device ACK bit.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic clk_sync;
    logic data_sync;
    logic clk_fall;

    ps2_line_sync u_sync (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    state_t                  state_q, state_d;
    logic [INH_W-1:0]        inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic [3:0]              bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic                    clk_oe_q, clk_oe_d;
    logic                    data_oe_q, data_oe_d;
    logic                    done_q, done_d;
    logic                    ack_err_q, ack_err_d;
    logic                    to_err_q, to_err_d;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            to_err_q  <= to_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        to_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = {1'b1, odd_parity(tx_data), tx_data};
                    inh_cnt_d = INH_LOAD;
                    clk_oe_d  = 1'b1;
                    data_oe_d = (INHIBIT_CYCLES == 1);
                    state_d   = INHIBIT;
                end
            end

            // Outputs are registered, so the start bit is scheduled one cycle
            // ahead to be on the line during the final inhibit cycle.
            INHIBIT: begin
                inh_cnt_d = inh_cnt_q - 1'b1;
                if (inh_cnt_q == INH_W'(1)) begin
                    data_oe_d = 1'b1;
                end
                if (inh_cnt_q == '0) begin
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    to_cnt_d  = '0;
                    bit_idx_d = '0;
                    state_d   = RTS;
                end
            end

            RTS, SHIFT, ACK, WAIT_IDLE: begin
                // Timeout is checked first so it wins over a coincident fall.
                if (to_cnt_q == TO_LAST) begin
                    to_err_d  = 1'b1;
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                    case (state_q)
                        RTS: begin
                            if (clk_fall) begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                                bit_idx_d = 4'd1;
                                state_d   = SHIFT;
                            end
                        end
                        SHIFT: begin
                            if (clk_fall) begin
                                data_oe_d = ~shift_q[0];
                                shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
                                bit_idx_d = bit_idx_q + 4'd1;
                                if (bit_idx_q == 4'd9) begin
                                    state_d = ACK;
                                end
                            end
                        end
                        ACK: begin
                            if (clk_fall) begin
                                if (data_sync) begin
                                    ack_err_d = 1'b1;
                                    clk_oe_d  = 1'b0;
                                    data_oe_d = 1'b0;
                                    state_d   = IDLE;
                                end else begin
                                    state_d = WAIT_IDLE;
                                end
                            end
                        end
                        WAIT_IDLE: begin
                            if (clk_sync && data_sync) begin
                                done_d  = 1'b1;
                                state_d = IDLE;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign tx_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = to_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares the sampled bits with a frame built from the command byte.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 5000;
    localparam int TOC = 2000;
    localparam int HP  = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

    int total = 0;
    int bad = 0;

    always #10 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TOC)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_in (ps2_clk_line),
        .ps2_data_in(ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    // Passive monitor, sampled on the falling clock edge.
    int   cyc = 0, oe_run = 0, last_run = 0, rts_cyc = 0, to_cyc = 0;
    int   n_done = 0, n_ack = 0, n_to = 0, n_acc = 0, n_multi = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2_clk_oe) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            last_run <= oe_run;
            oe_run   <= 0;
        end
        if (prev_clk_oe && !ps2_clk_oe) rts_cyc <= cyc;
        prev_clk_oe <= ps2_clk_oe;
        if (done) n_done <= n_done + 1;
        if (ack_err) n_ack <= n_ack + 1;
        if (timeout_err) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (int'(done) + int'(ack_err) + int'(timeout_err) > 1) n_multi <= n_multi + 1;
        if (tx_valid && tx_ready && clrn) n_acc <= n_acc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame as the device should see it: 8 data bits LSB first,
    // odd parity (set when the data holds an even count of ones), stop bit.
    function automatic logic [9:0] ref_frame(input logic [7:0] b);
        logic [9:0] f;
        int v = int'(b);
        int ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = (v % 2) == 1;
            ones += v % 2;
            v = v / 2;
        end
        f[8] = (ones % 2) == 0;
        f[9] = 1'b1;
        return f;
    endfunction

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_rts(output logic seen);
        int w = 0;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && w < INH + 100) begin
            tick(1);
            w++;
        end
        seen = (w < INH + 100);
        check("rts_seen", seen, 1);
    endtask

    // Device model: clocks the frame, samples data on each rising edge,
    // then drives (or withholds) the ACK bit on the 11th clock.
    task automatic dev_xfer(input bit nack, input int stop_after,
                            output logic [9:0] got, output logic start_ok);
        logic seen;
        got      = '0;
        start_ok = 1'b0;
        wait_rts(seen);
        if (!seen) return;
        start_ok = !ps2_data_line;
        tick(HP);
        for (int i = 1; i <= 10; i++) begin
            dev_clk_low = 1'b1;
            tick(HP);
            if (i == stop_after) return;
            got[i-1]    = ps2_data_line;
            dev_clk_low = 1'b0;
            tick(HP);
        end
        if (!nack) dev_data_low = 1'b1;
        tick(4);
        dev_clk_low = 1'b1;
        tick(HP);
        dev_clk_low = 1'b0;
        tick(4);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (!tx_ready && w < 200) begin
            tick(1);
            w++;
        end
        check(tag, tx_ready, 1);
        tick(2);
    endtask

    initial begin
        logic [9:0] got;
        logic       st, seen;
        logic [7:0] b, first;
        int         d0, a0, t0, c0, w;

        // Reset state
        tick(3);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {done, ack_err, timeout_err}, 0);
        clrn = 1'b1;
        tick(2);

        // 0xED with ACK
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(CMD_SET_LED);
        dev_xfer(1'b0, 0, got, st);
        wait_ready("ed_ready");
        check("ed_inhibit_len", last_run, INH);
        check("ed_start_bit", st, 1);
        check("ed_bits_const", got, 10'b11_1110_1101);
        check("ed_bits_model", got, ref_frame(CMD_SET_LED));
        check("ed_done", n_done - d0, 1);
        check("ed_no_err", (n_ack - a0) + (n_to - t0), 0);

        // 0xF4: odd number of ones gives parity 0
        d0 = n_done; a0 = n_ack; t0 = n_to;
        send(CMD_ENABLE);
        dev_xfer(1'b0, 0, got, st);
        wait_ready("f4_ready");
        check("f4_parity", got[8], 0);
        check("f4_bits_model", got, ref_frame(CMD_ENABLE));
        check("f4_done", n_done - d0, 1);
        check("f4_ack_err", n_ack - a0, 0);
        check("f4_timeout", n_to - t0, 0);

        // Device withholds ACK
        d0 = n_done; a0 = n_ack;
        b = 8'($urandom);
        send(b);
        dev_xfer(1'b1, 0, got, st);
        wait_ready("nack_ready");
        check("nack_bits_model", got, ref_frame(b));
        check("nack_ack_err", n_ack - a0, 1);
        check("nack_no_done", n_done - d0, 0);
        check("nack_oe", {ps2_clk_oe, ps2_data_oe}, 0);

        // Device never clocks
        d0 = n_done; t0 = n_to;
        send(8'($urandom));
        wait_rts(seen);
        w = 0;
        while (!timeout_err && w < TOC + 100) begin
            tick(1);
            w++;
        end
        check("to_seen", timeout_err, 1);
        check("to_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        tick(2);
        check("to_latency", to_cyc - rts_cyc, TOC);
        check("to_count", n_to - t0, 1);
        check("to_no_done", n_done - d0, 0);
        check("to_idle", tx_ready, 1);

        // Asynchronous reset after the 4th fall (bit 3 of 0x00 pulls data low)
        send(8'h00);
        dev_xfer(1'b0, 4, got, st);
        check("pre_rst_data_oe", ps2_data_oe, 1);
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        dev_clk_low = 1'b0;
        tick(2);
        clrn = 1'b1;
        tick(1);
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_busy", busy, 0);
        d0 = n_done;
        send(CMD_RESET);
        dev_xfer(1'b0, 0, got, st);
        wait_ready("ff_ready");
        check("ff_bits_model", got, ref_frame(CMD_RESET));
        check("ff_done", n_done - d0, 1);

        // tx_valid held high with changing data while busy
        d0 = n_done; c0 = n_acc;
        first    = 8'($urandom);
        tx_data  = first;
        tx_valid = 1'b1;
        tick(1);
        for (int i = 0; i < 50; i++) begin
            tx_data = 8'($urandom);
            tick(1);
        end
        dev_xfer(1'b0, 0, got, st);
        tx_valid = 1'b0;
        wait_ready("hold_ready");
        check("hold_bits_model", got, ref_frame(first));
        check("hold_accepts", n_acc - c0, 1);
        check("hold_done", n_done - d0, 1);

        // Randomised bytes
        for (int k = 0; k < 3; k++) begin
            d0 = n_done;
            b  = 8'($urandom);
            send(b);
            dev_xfer(1'b0, 0, got, st);
            wait_ready("rnd_ready");
            check("rnd_bits_model", got, ref_frame(b));
            check("rnd_inhibit_len", last_run, INH);
            check("rnd_done", n_done - d0, 1);
        end

        check("pulse_exclusive", n_multi, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
